// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: redirect input, instruction-memory port, decode-side
// instruction stream and buffer occupancy.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic [CNT_W-1:0]      buf_count;

  // Fetch-unit side.
  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, buf_count
  );

  // Execute / memory / decode side.
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, buf_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fixed-latency memory reads, buffers
// {pc, instr} pairs in a circular buffer, and restarts fetch on redirect.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic      clk,
  input  logic      rst,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  entry_t                r_mem [DEPTH];

  logic [CNT_W:0]        w_occupancy;
  logic                  w_req;
  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffered entries plus the one in flight must fit, so a returning
  // response always has a free slot.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_req       = rst && !bus.redirect_valid &&
                       (w_occupancy < (CNT_W + 1)'(DEPTH));
  assign w_valid     = (r_count != '0) && !bus.redirect_valid;
  assign w_push      = r_inflight && !bus.redirect_valid;
  assign w_pop       = w_valid && bus.instr_ready;
  assign w_target    = bus.redirect_pc & ~DATA_WIDTH'(3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + DATA_WIDTH'(4);
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      // NOTE: the empty default keeps the count on push+pop without
      // needing a separate hold branch.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: buffer storage is not reset; an entry is only observed after a
  // push has written it, and r_count guards every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: r_inflight_pc, instr: bus.imem_rdata};
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_mem[r_rd_ptr].instr;
  assign bus.instr_pc    = r_mem[r_rd_ptr].pc;
  assign bus.buf_count   = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_pop && !w_push && (r_count == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences and random
// stimulus against a queue-based reference model (DEPTH=4), plus a DEPTH=2 run.
module tb_fetch_unit;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam int          D4   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_WIDTH(32), .DEPTH(4)) bus4 ();
  fetch_unit_if #(.DATA_WIDTH(32), .DEPTH(2)) bus2 ();

  fetch_unit #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.master));
  fetch_unit #(.DATA_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master));

  // One-cycle memory; idle cycles return a poison word.
  always @(posedge clk) begin
    bus4.imem_rdata <= bus4.imem_req ? (bus4.imem_addr ^ MASK) : 32'hDEAD_BEEF;
    bus2.imem_rdata <= bus2.imem_req ? (bus2.imem_addr ^ MASK) : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, instr} plus one pending request.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetch;

  bit          cur_ready, cur_redir, cur_req, cur_valid;
  logic [31:0] cur_rpc;

  task automatic model_reset();
    m_q.delete();
    m_pend    = 1'b0;
    m_pend_pc = 32'h0;
    m_fetch   = 32'h0;
  endtask

  // Drive one cycle's inputs at the falling edge and compare against the model.
  task automatic apply(input bit ready, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    bus4.instr_ready    = ready;
    bus4.redirect_valid = redir;
    bus4.redirect_pc    = rpc;
    cur_ready = ready;
    cur_redir = redir;
    cur_rpc   = rpc;
    cur_req   = !redir && ((m_q.size() + int'(m_pend)) < D4);
    cur_valid = (m_q.size() != 0) && !redir;
    #1;
    check("m_imem_req",    bus4.imem_req,    cur_req);
    check("m_imem_addr",   bus4.imem_addr,   m_fetch);
    check("m_instr_valid", bus4.instr_valid, cur_valid);
    check("m_buf_count",   bus4.buf_count,   m_q.size());
    if (cur_valid) begin
      check("m_instr_pc", bus4.instr_pc, m_q[0].pc);
      check("m_instr",    bus4.instr,    m_q[0].instr);
    end
  endtask

  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (cur_redir) begin
      m_q.delete();
      m_pend  = 1'b0;
      m_fetch = {cur_rpc[31:2], 2'b00};
    end else begin
      if (cur_valid && cur_ready) e = m_q.pop_front();
      if (m_pend) m_q.push_back('{pc: m_pend_pc, instr: m_pend_pc ^ MASK});
      m_pend = cur_req;
      if (cur_req) begin
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic step(input bit ready, input bit redir, input logic [31:0] rpc);
    apply(ready, redir, rpc);
    advance();
  endtask

  // Hold reset across one rising edge; release just after it so the next
  // falling-edge sample is the first cycle out of reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_imem_req",    bus4.imem_req,    1'b0);
    check("rst_instr_valid", bus4.instr_valid, 1'b0);
    check("rst_buf_count",   bus4.buf_count,   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] exp_pc;
    bit          v1, v2;
    int          acc;

    bus4.instr_ready = 1'b0; bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0;
    bus2.instr_ready = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
    model_reset();

    // Cold start with ready held high, then a redirect to 0x103.
    vecs[0] = '{1, 0, 32'h0,   1, 32'h00,  0, 32'h0,   3'd0};
    vecs[1] = '{1, 0, 32'h0,   1, 32'h04,  0, 32'h0,   3'd0};
    vecs[2] = '{1, 0, 32'h0,   1, 32'h08,  1, 32'h0,   3'd1};
    vecs[3] = '{1, 0, 32'h0,   1, 32'h0C,  1, 32'h4,   3'd1};
    vecs[4] = '{1, 0, 32'h0,   1, 32'h10,  1, 32'h8,   3'd1};
    vecs[5] = '{1, 0, 32'h0,   1, 32'h14,  1, 32'hC,   3'd1};
    vecs[6] = '{1, 1, 32'h103, 0, 32'h18,  0, 32'h0,   3'd1};
    vecs[7] = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   3'd0};
    vecs[8] = '{1, 0, 32'h0,   1, 32'h104, 0, 32'h0,   3'd0};
    vecs[9] = '{1, 0, 32'h0,   1, 32'h108, 1, 32'h100, 3'd1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      check($sformatf("vec%0d_req", i),   bus4.imem_req,    vecs[i].e_req);
      check($sformatf("vec%0d_addr", i),  bus4.imem_addr,   vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), bus4.instr_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_count", i), bus4.buf_count,   vecs[i].e_count);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_pc", i),    bus4.instr_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_instr", i), bus4.instr,    vecs[i].e_pc ^ MASK);
      end
      advance();
    end

    // Back-to-back redirects: the second target wins.
    apply(1, 1, 32'h200); advance();
    apply(1, 1, 32'h302);
    check("b2b_valid_r", bus4.instr_valid, 1'b0);
    advance();
    apply(1, 0, 0); check("b2b_addr_r1", bus4.imem_addr, 32'h300); advance();
    apply(1, 0, 0); check("b2b_valid_r2", bus4.instr_valid, 1'b0); advance();
    apply(1, 0, 0); check("b2b_pc_r3", bus4.instr_pc, 32'h300); advance();

    // Back-pressure: four requests, then the buffer fills and holds.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      apply(0, 0, 0);
      check("bp_req_early", bus4.imem_req, 1'b1);
      advance();
    end
    for (int c = 4; c < 10; c++) begin
      apply(0, 0, 0);
      check("bp_req_stalled", bus4.imem_req, 1'b0);
      if (c >= 5) check("bp_count_full", bus4.buf_count, 32'd4);
      advance();
    end
    // First pop frees a slot; address 16 is requested only afterwards.
    exp_pc = 32'h0;
    for (int c = 0; c < 16; c++) begin
      apply((c % 5) != 3, 0, 0);
      if (c == 0) check("bp_no_req_at_pop", bus4.imem_req, 1'b0);
      if (c == 1) begin
        check("bp_req_after_pop", bus4.imem_req, 1'b1);
        check("bp_addr16", bus4.imem_addr, 32'h10);
      end
      check("full_count_le4", bus4.buf_count <= 3'd4, 1'b1);
      if (bus4.instr_valid && cur_ready) begin
        check("full_seq_pc", bus4.instr_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      advance();
    end

    // Reset mid-stream with three entries buffered and one in flight.
    do_reset();
    for (int c = 0; c < 4; c++) step(0, 0, 0);
    @(negedge clk);
    #1;
    check("mid_pre_count", bus4.buf_count, 32'd3);
    rst = 1'b0;
    #1;
    check("mid_rst_count", bus4.buf_count,   32'd0);
    check("mid_rst_valid", bus4.instr_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(1, 0, 0); check("mid_c0_addr", bus4.imem_addr, 32'h0); advance();
    apply(1, 0, 0); check("mid_c1_count", bus4.buf_count, 32'd0); advance();
    apply(1, 0, 0); check("mid_c2_pc", bus4.instr_pc, 32'h0); advance();
    apply(1, 0, 0); check("mid_c3_pc", bus4.instr_pc, 32'h4); advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);

    // DEPTH=2 instance with ready held high.
    bus4.redirect_valid = 1'b0;
    do_reset();
    exp_pc = 32'h0; v1 = 1'b0; v2 = 1'b0; acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      check("d2_count_le2", bus2.buf_count <= 2'd2, 1'b1);
      if (c < 2)  check("d2_cold_valid", bus2.instr_valid, 1'b0);
      if (c == 2) check("d2_first_valid", bus2.instr_valid, 1'b1);
      if (bus2.instr_valid) begin
        check("d2_pc", bus2.instr_pc, exp_pc);
        check("d2_instr", bus2.instr, exp_pc ^ MASK);
        exp_pc = exp_pc + 32'd4;
        acc++;
      end
      if (c >= 2) check("d2_below_full_rate", v2 & v1 & bus2.instr_valid, 1'b0);
      v2 = v1;
      v1 = bus2.instr_valid;
    end
    check("d2_accepted_min", acc >= 15, 1'b1);
    check("d2_accepted_max", acc <= 20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
